// File: rtl/xor_stream_cipher.sv
// Serial-loaded XOR stream cipher: shifts in a key, then XORs framed message bits against it.
// Optional build macro XOR_KEY_ROTATE_EN: rotate the working key left by one on each key wrap inside a frame.
module xor_stream_cipher #(
   parameter int KEY_BITS = 32,
   parameter int MSG_BITS = 512
) (
   input  logic iClk,
   input  logic iRst,
   input  logic iEn,
   input  logic iSerial_in,
   input  logic iLoad_key,
   input  logic iLoad_msg,
   output logic oSerial_out,
   output logic oSerial_start,
   output logic oSerial_end,
   output logic oKey_valid,
   output logic oBusy
);

   localparam int KCW = $clog2(KEY_BITS) + 1;
   localparam int FCW = $clog2(MSG_BITS) + 1;
   localparam int IW  = $clog2(KEY_BITS);
   localparam logic [KCW-1:0] KEY_LAST   = KCW'(KEY_BITS - 1);
   localparam logic [FCW-1:0] FRAME_LAST = FCW'(MSG_BITS - 1);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_LOAD_KEY = 2'd1,
      ST_STREAM   = 2'd2
   } state_t;

   state_t r_state;
   state_t w_state_next;

   logic [KEY_BITS-1:0] r_base_key;
   logic [KEY_BITS-1:0] r_work_key;
   logic [KCW-1:0]      r_key_cnt;
   logic [KCW-1:0]      r_idx;
   logic [FCW-1:0]      r_frame_cnt;
   logic                r_key_valid;
   logic                r_out;
   logic                r_start;
   logic                r_end;
   logic                r_busy;

   logic w_key_bit;
   logic w_key_done;
   logic w_msg_acc;
   logic w_frame_first;
   logic w_frame_last;
   logic w_idx_wrap;
   logic w_key_sel;

   assign w_key_bit     = iEn & iLoad_key;
   assign w_key_done    = w_key_bit & (r_key_cnt == KEY_LAST);
   assign w_msg_acc     = iEn & iLoad_msg & ~iLoad_key & r_key_valid;
   assign w_frame_first = (r_frame_cnt == '0);
   assign w_frame_last  = (r_frame_cnt == FRAME_LAST);
   assign w_idx_wrap    = (r_idx == '0);
   // The working key is only refreshed at the frame's first bit, so that bit reads the base key directly.
   assign w_key_sel     = w_frame_first ? r_base_key[KEY_BITS-1] : r_work_key[r_idx[IW-1:0]];

   always_ff @(posedge iClk or negedge iRst) begin
      if (!iRst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      if (iEn) begin
         case (r_state)
            ST_IDLE: begin
               if (iLoad_key)      w_state_next = ST_LOAD_KEY;
               else if (w_msg_acc) w_state_next = ST_STREAM;
            end
            ST_LOAD_KEY: begin
               if (!iLoad_key || w_key_done) w_state_next = ST_IDLE;
            end
            ST_STREAM: begin
               if (iLoad_key)                         w_state_next = ST_LOAD_KEY;
               else if (w_msg_acc && w_frame_last)    w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge iClk or negedge iRst) begin
      if (!iRst) begin
         r_base_key  <= '0;
         r_work_key  <= '0;
         r_key_cnt   <= '0;
         r_idx       <= KEY_LAST;
         r_frame_cnt <= '0;
         r_key_valid <= 1'b0;
         r_out       <= 1'b0;
         r_start     <= 1'b0;
         r_end       <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_start <= w_msg_acc & w_frame_first;
         r_end   <= w_msg_acc & w_frame_last;
         if (w_key_bit) begin
            r_base_key <= {r_base_key[KEY_BITS-2:0], iSerial_in};
            if (r_key_cnt == '0) r_key_valid <= 1'b0;
            if (w_key_done) begin
               r_key_cnt   <= '0;
               r_key_valid <= 1'b1;
            end else begin
               r_key_cnt <= r_key_cnt + 1'b1;
            end
            // Key traffic always abandons any frame in flight.
            r_frame_cnt <= '0;
            r_idx       <= KEY_LAST;
            r_busy      <= 1'b0;
         end else if (iEn) begin
            r_key_cnt <= '0;
            if (w_msg_acc) begin
               r_out <= iSerial_in ^ w_key_sel;
               if (w_frame_first) r_work_key <= r_base_key;
               if (w_frame_last) begin
                  r_frame_cnt <= '0;
                  r_idx       <= KEY_LAST;
                  r_busy      <= 1'b0;
               end else begin
                  r_frame_cnt <= r_frame_cnt + 1'b1;
                  r_busy      <= 1'b1;
                  if (w_idx_wrap) begin
                     r_idx <= KEY_LAST;
`ifdef XOR_KEY_ROTATE_EN
                     r_work_key <= {r_work_key[KEY_BITS-2:0], r_work_key[KEY_BITS-1]};
`else
                     r_work_key <= r_work_key;
`endif
                  end else begin
                     r_idx <= r_idx - 1'b1;
                  end
               end
            end
         end
      end
   end

   assign oSerial_out   = r_out;
   assign oSerial_start = r_start;
   assign oSerial_end   = r_end;
   assign oKey_valid    = r_key_valid;
   assign oBusy         = r_busy;

endmodule

// File: tb/tb_xor_stream_cipher.sv
// Bench for xor_stream_cipher (KEY_BITS=8, MSG_BITS=16): frame-level reference model plus directed literal checks.
`timescale 1ns/1ps
module tb_xor_stream_cipher;

   localparam int KB = 8;
   localparam int MB = 16;

`ifdef XOR_KEY_ROTATE_EN
   localparam logic [15:0] EXP_F0 = 16'hFF11;
   localparam logic [15:0] EXP_3C = 16'h3C78;
   localparam logic [15:0] EXP_AA = 16'hAA55;
   localparam logic [15:0] EXP_5A = 16'h5AB4;
`else
   localparam logic [15:0] EXP_F0 = 16'hFF00;
   localparam logic [15:0] EXP_3C = 16'h3C3C;
   localparam logic [15:0] EXP_AA = 16'hAAAA;
   localparam logic [15:0] EXP_5A = 16'h5A5A;
`endif

   logic iClk, iRst, iEn, iSerial_in, iLoad_key, iLoad_msg;
   logic oSerial_out, oSerial_start, oSerial_end, oKey_valid, oBusy;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state: frame position and the key captured when the frame began.
   logic [7:0] m_key, m_fkey;
   int         m_kbits, m_pos;
   logic       m_valid, m_out, m_start, m_end, m_busy, m_emit;

   logic        mon_en = 1'b0;
   logic [15:0] cap = '0;
   int cap_n = 0, start_pos = 0, end_pos = 0, n_start = 0, n_end = 0;
   int base, s0, e0;

   xor_stream_cipher #(.KEY_BITS(KB), .MSG_BITS(MB)) dut (
      .iClk          (iClk),
      .iRst          (iRst),
      .iEn           (iEn),
      .iSerial_in    (iSerial_in),
      .iLoad_key     (iLoad_key),
      .iLoad_msg     (iLoad_msg),
      .oSerial_out   (oSerial_out),
      .oSerial_start (oSerial_start),
      .oSerial_end   (oSerial_end),
      .oKey_valid    (oKey_valid),
      .oBusy         (oBusy)
   );

   always #5 iClk = ~iClk;

   // Key bit used for frame position pos: key rotated once per completed key pass (if enabled), MSB first.
   function automatic logic key_bit(input logic [7:0] k, input int pos);
      logic [7:0] r;
      r = k;
`ifdef XOR_KEY_ROTATE_EN
      for (int j = 0; j < pos / KB; j++) r = {r[6:0], r[7]};
`endif
      return r[KB - 1 - (pos % KB)];
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model();
      forever begin
         @(posedge iClk or negedge iRst);
         if (!iRst) begin
            m_key = '0; m_fkey = '0; m_kbits = 0; m_pos = 0; m_valid = 0;
            m_out = 0; m_start = 0; m_end = 0; m_busy = 0; m_emit = 0;
         end else begin
            m_emit = 0; m_start = 0; m_end = 0;
            if (iEn && iLoad_key) begin
               m_key = {m_key[6:0], iSerial_in};
               m_kbits++;
               if (m_kbits == 1) m_valid = 0;
               if (m_kbits == KB) begin
                  m_valid = 1;
                  m_kbits = 0;
               end
               m_pos = 0;
               m_busy = 0;
            end else if (iEn) begin
               m_kbits = 0;
               if (iLoad_msg && m_valid) begin
                  if (m_pos == 0) m_fkey = m_key;
                  m_out   = iSerial_in ^ key_bit(m_fkey, m_pos);
                  m_start = (m_pos == 0);
                  m_end   = (m_pos == MB - 1);
                  m_emit  = 1;
                  m_pos   = (m_pos + 1) % MB;
                  m_busy  = (m_pos != 0);
               end
            end
         end
      end
   endtask

   task automatic monitor();
      forever begin
         @(negedge iClk);
         if (mon_en) begin
            chk("out",       oSerial_out,   m_out);
            chk("start",     oSerial_start, m_start);
            chk("end",       oSerial_end,   m_end);
            chk("key_valid", oKey_valid,    m_valid);
            chk("busy",      oBusy,         m_busy);
            if (m_emit) begin
               cap = {cap[14:0], oSerial_out};
               cap_n++;
               if (oSerial_start) start_pos = cap_n;
               if (oSerial_end)   end_pos   = cap_n;
            end
            if (oSerial_start) n_start++;
            if (oSerial_end)   n_end++;
         end
      end
   endtask

   task automatic drive(input logic en, input logic ld_k, input logic ld_m, input logic sin);
      iEn = en; iLoad_key = ld_k; iLoad_msg = ld_m; iSerial_in = sin;
      @(negedge iClk);
   endtask

   task automatic load_key(input logic [7:0] k, input int n);
      for (int i = 0; i < n; i++) drive(1'b1, 1'b1, 1'b0, k[7-i]);
      drive(1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic send_word(input logic [15:0] w);
      for (int i = 0; i < 16; i++) drive(1'b1, 1'b0, 1'b1, w[15-i]);
   endtask

   task automatic mark();
      base = cap_n; s0 = n_start; e0 = n_end;
   endtask

   task automatic pulse_reset();
      iEn = 0; iLoad_key = 0; iLoad_msg = 0; iSerial_in = 0;
      #2 iRst = 1'b0;
      @(negedge iClk);
      #2 iRst = 1'b1;
      @(negedge iClk);
   endtask

   initial begin
      iClk = 0; iRst = 1; iEn = 0; iSerial_in = 0; iLoad_key = 0; iLoad_msg = 0;
      fork
         model();
         monitor();
      join_none
      #2 iRst = 1'b0;
      #1;
      chk("rst_out",   oSerial_out, 0);
      chk("rst_valid", oKey_valid,  0);
      chk("rst_busy",  oBusy,       0);
      chk("rst_start", oSerial_start, 0);
      mon_en = 1'b1;
      @(negedge iClk);
      #2 iRst = 1'b1;
      @(negedge iClk);

      // Key 0xF0, message 0x0FF0.
      load_key(8'hF0, 8);
      chk("f0_key_valid", oKey_valid, 1);
      mark();
      send_word(16'h0FF0);
      #1;
      chk("f0_cipher",    cap, EXP_F0);
      chk("f0_len",       cap_n - base, 16);
      chk("f0_start_pos", start_pos - base, 1);
      chk("f0_end_pos",   end_pos - base, 16);
      chk("f0_nstart",    n_start - s0, 1);
      chk("f0_nend",      n_end - e0, 1);
      chk("f0_busy_end",  oBusy, 0);
      $display("[TB] frame key=f0 msg=0ff0 out=%h", cap);
      drive(1'b1, 1'b0, 1'b0, 1'b0);

      // Two back-to-back frames of zeros under key 0x3C.
      load_key(8'h3C, 8);
      mark();
      send_word(16'h0000);
      #1;
      chk("3c_frame1", cap, EXP_3C);
      $display("[TB] frame key=3c msg=0000 out=%h", cap);
      send_word(16'h0000);
      #1;
      chk("3c_frame2",  cap, EXP_3C);
      chk("3c_nstart",  n_start - s0, 2);
      chk("3c_nend",    n_end - e0, 2);
      $display("[TB] frame key=3c msg=0000 out=%h", cap);
      drive(1'b1, 1'b0, 1'b0, 1'b0);

      // Truncated key load leaves no valid key; message bits are ignored.
      pulse_reset();
      load_key(8'hFF, 8);
      load_key(8'h00, 5);
      chk("trunc_valid", oKey_valid, 0);
      mark();
      send_word(16'hFFFF);
      #1;
      chk("trunc_out",    oSerial_out, 0);
      chk("trunc_nstart", n_start - s0, 0);
      $display("[TB] truncated key load, valid=%0b out=%0b", oKey_valid, oSerial_out);

      // Key and message strobes together: key wins, no frame starts.
      mark();
      for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, 1'b1, (i % 2) == 0);
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      chk("both_valid",  oKey_valid, 1);
      chk("both_nstart", n_start - s0, 0);
      send_word(16'h0000);
      #1;
      chk("both_key_aa", cap, EXP_AA);
      $display("[TB] frame key=aa (both strobes) out=%h", cap);
      drive(1'b1, 1'b0, 1'b0, 1'b0);

      // Reset mid-frame clears everything and forces a key reload.
      load_key(8'h5A, 8);
      for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 1'b1, 1'b1);
      #2 iRst = 1'b0;
      #1;
      chk("mrst_out",   oSerial_out, 0);
      chk("mrst_valid", oKey_valid,  0);
      chk("mrst_busy",  oBusy,       0);
      @(negedge iClk);
      #2 iRst = 1'b1;
      @(negedge iClk);
      mark();
      send_word(16'h1234);
      #1;
      chk("mrst_nstart", n_start - s0, 0);
      load_key(8'h5A, 8);
      mark();
      send_word(16'h0000);
      #1;
      chk("mrst_reload", cap, EXP_5A);
      chk("mrst_nstart2", n_start - s0, 1);
      $display("[TB] frame after reset key=5a out=%h", cap);
      drive(1'b1, 1'b0, 1'b0, 1'b0);

      // Randomized traffic: pauses, enable gaps, aborts, partial keys, resets.
      load_key(8'($urandom), 8);
      for (int t = 0; t < 150; t++) begin
         int op;
         int n;
         op = $urandom_range(0, 15);
         if (op == 15) begin
            pulse_reset();
            $display("[TB] op %0d: reset pulse", t);
         end else if (op < 3) begin
            n = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 8;
            load_key(8'($urandom), n);
            $display("[TB] op %0d: key load %0d bits", t, n);
         end else if (op == 3) begin
            n = $urandom_range(1, 10);
            for (int i = 0; i < n; i++) drive(1'b1, 1'b1, 1'b1, 1'($urandom));
            $display("[TB] op %0d: key+msg strobes %0d cycles", t, n);
         end else if (op == 4) begin
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) drive(1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
            $display("[TB] op %0d: enable low %0d cycles", t, n);
         end else begin
            n = $urandom_range(1, 24);
            for (int i = 0; i < n; i++)
               drive($urandom_range(0, 9) != 0, $urandom_range(0, 39) == 0,
                     $urandom_range(0, 4) != 0, 1'($urandom));
            $display("[TB] op %0d: message chunk %0d cycles", t, n);
         end
      end
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      #1;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/xor_stream_cipher.md
XOR_STREAM_CIPHER -- requirements
Module: xor_stream_cipher

Interface
REQ-001 SHALL have parameter KEY_BITS, default 32, meaning key length in bits (legal range 2..256).
REQ-002 SHALL have parameter MSG_BITS, default 512, meaning frame length in bits (legal range 2..4096).
REQ-003 SHALL have port iClk, input, 1 bit: single clock; all state rising-edge.
REQ-004 SHALL have port iRst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port iEn, input, 1 bit: global enable; low freezes all state.
REQ-006 SHALL have port iSerial_in, input, 1 bit: shared serial data for key and message, MSB-first.
REQ-007 SHALL have port iLoad_key, input, 1 bit: high marks iSerial_in as a key bit.
REQ-008 SHALL have port iLoad_msg, input, 1 bit: high marks iSerial_in as a message bit.
REQ-009 SHALL have port oSerial_out, output, 1 bit: ciphertext bit, registered.
REQ-010 SHALL have port oSerial_start, output, 1 bit: one-cycle strobe on the first ciphertext bit of a frame.
REQ-011 SHALL have port oSerial_end, output, 1 bit: one-cycle strobe on the MSG_BITS-th ciphertext bit of a frame.
REQ-012 SHALL have port oKey_valid, output, 1 bit: a complete key is held.
REQ-013 SHALL have port oBusy, output, 1 bit: a frame is in progress (bits 1..MSG_BITS-1 emitted).

Function
REQ-014 SHALL implement FSM IDLE/LOAD_KEY/STREAM; IDLE->LOAD_KEY on iLoad_key; LOAD_KEY->IDLE on key complete or abort; IDLE->STREAM on accepted message bit with oKey_valid; STREAM->IDLE after the oSerial_end bit.
REQ-015 SHALL, while iEn&iLoad_key, shift iSerial_in into a base key register MSB-first; oKey_valid is cleared on the first key bit and set the cycle after the KEY_BITS-th bit.
REQ-016 SHALL, if iLoad_key drops before KEY_BITS bits, clear the key bit counter and leave oKey_valid=0.
REQ-017 SHALL accept a message bit when iEn&iLoad_msg&~iLoad_key&oKey_valid; other message bits are ignored.
REQ-018 SHALL output, one cycle after acceptance, oSerial_out = message bit XOR working_key[idx]; idx starts at KEY_BITS-1 each frame, decrements per accepted bit, wraps to KEY_BITS-1 after 0.
REQ-019 SHALL copy the base key into the working key at each frame start.
REQ-020 SHALL count frame bits 0..MSG_BITS-1, wrap to 0 after oSerial_end; the next accepted bit starts a new frame with oSerial_start.
REQ-021 SHALL assert oSerial_start and oSerial_end together only if MSG_BITS=1 (illegal); otherwise never simultaneously.
REQ-022 SHALL pause (hold counters, idx, oBusy) when iLoad_msg is low mid-frame; oSerial_start/oSerial_end low during pause.
REQ-023 SHALL, on iLoad_key mid-frame, abort the frame: frame counter and idx reset, oBusy=0, no oSerial_end emitted.
REQ-024 SHALL give iLoad_key priority when iLoad_key and iLoad_msg are both high; the message bit is dropped.
REQ-025 SHALL, with iEn low, hold oSerial_out and drive oSerial_start/oSerial_end low.
REQ-026 SHALL size counters as $clog2(KEY_BITS)+1 and $clog2(MSG_BITS)+1 bits.

Reset
REQ-027 SHALL on iRst low asynchronously clear base key, working key, all counters, idx to KEY_BITS-1, FSM to IDLE, and all outputs to 0.
REQ-028 SHALL release reset without output glitches; the first accepted bit after release is processed normally.

Configuration
REQ-029 SHALL, with XOR_KEY_ROTATE_EN defined, rotate the working key left by 1 bit each time idx wraps within a frame (base key unchanged).
REQ-030 SHALL, without XOR_KEY_ROTATE_EN, reuse the working key unchanged for the entire frame.

Verification (KEY_BITS=8, MSG_BITS=16)
REQ-031 SHALL cover: load key 0xF0, stream 0x0FF0 -> output 0xFF00, oSerial_start on bit 1, oSerial_end on bit 16, 1-cycle latency.
REQ-032 SHALL cover with XOR_KEY_ROTATE_EN: key 0xF0, stream 0x0FF0 -> output 0xFF11.
REQ-033 SHALL cover: 5 key bits then iLoad_key low -> oKey_valid=0; message bits ignored, oSerial_out stays 0.
REQ-034 SHALL cover: iLoad_key and iLoad_msg both high for 8 cycles with 0xAA -> key=0xAA, oSerial_start never asserts.
REQ-035 SHALL cover: iRst low after 10 message bits -> all outputs 0, oKey_valid=0, next frame requires key reload.
REQ-036 SHALL cover: two back-to-back frames of 0x0000 with key 0x3C -> output 0x3C3C twice, two start/end strobe pairs.
